// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | ready for a request; fast-path results are registered here
// CALC  | one shift-add or restoring-divide iteration per clock
// DONE  | result presented, held until out_ready
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_data
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;   // product accumulator / partial remainder
  logic [2*XLEN-1:0]   opa_q, opa_d;   // shifted multiplicand / dividend-quotient
  logic [XLEN-1:0]     opb_q, opb_d;   // multiplier magnitude / divisor magnitude
  logic [XLEN-1:0]     res_q, res_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;

  logic                s1, s2, is_mul, last;
  logic                rs2_zero, div_ovf, fast;
  logic [XLEN-1:0]     mag1, mag2, fast_res;
  logic [XLEN:0]       shifted;
  logic [XLEN+1:0]     diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    last     = 1'b0;
    shifted  = '0;
    diff     = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;
    is_mul   = !op_q[2];

    s1 = in_rs1[XLEN-1] & ((in_funct3 == F_MULH) | (in_funct3 == F_MULHSU) |
                           (in_funct3 == F_DIV)  | (in_funct3 == F_REM));
    s2 = in_rs2[XLEN-1] & ((in_funct3 == F_MULH) | (in_funct3 == F_DIV) |
                           (in_funct3 == F_REM));
    mag1 = s1 ? -in_rs1 : in_rs1;
    mag2 = s2 ? -in_rs2 : in_rs2;

    rs2_zero = (in_rs2 == '0);
    div_ovf  = !in_funct3[0] && (in_rs1 == INT_MIN) && (in_rs2 == ONES);
    fast     = in_funct3[2] && (rs2_zero || div_ovf);
    if (rs2_zero)
      fast_res = in_funct3[1] ? in_rs1 : ONES;
    else
      fast_res = in_funct3[1] ? '0 : INT_MIN;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = in_funct3;
          rd_d   = in_rd;
          cnt_d  = '0;
          acc_d  = '0;
          opa_d  = {{XLEN{1'b0}}, mag1};
          opb_d  = mag2;
          negq_d = s1 ^ s2;
          negr_d = s1;
          if (fast) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mul) begin
          acc_d = acc_q + (opb_q[0] ? opa_q : '0);
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          // Restoring step: keep the trial difference only when it did not go negative.
          shifted = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
          diff    = {1'b0, shifted} - {2'b00, opb_q};
          acc_d   = diff[XLEN+1] ? {{(XLEN-1){1'b0}}, shifted}
                                 : {{(XLEN-1){1'b0}}, diff[XLEN:0]};
          opa_d   = {{XLEN{1'b0}}, opa_q[XLEN-2:0], ~diff[XLEN+1]};
        end
`ifdef MULDIV_EARLY_OUT_EN
        last = (cnt_q == CW'(XLEN-1)) || (is_mul && (opb_d == '0));
`else
        last = (cnt_q == CW'(XLEN-1));
`endif
        if (last) begin
          prod = negq_q ? -acc_d : acc_d;
          quo  = negq_q ? -opa_d[XLEN-1:0] : opa_d[XLEN-1:0];
          rem  = negr_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
          if (is_mul)
            res_d = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          else
            res_d = op_q[1] ? rem : quo;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_rd    = rd_q;
  assign out_data  = res_q;
  assign out_we    = out_valid && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, fast paths, backpressure, reset mid-op.
// Define MULDIV_EARLY_OUT_EN for both files to check the early-out multiply latency.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
    .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat = clock edges after the accept edge before out_valid is seen (0 = next cycle)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, output int lat);
    issue(f, a, b, rd);
    wait_valid(lat);
    chk(tag, out_data, exp);
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    chk({tag, "_we"}, {31'd0, out_we}, {31'd0, rd != 5'd0});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int ghost;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_we", {31'd0, out_we}, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, lat);
`ifdef MULDIV_EARLY_OUT_EN
    chk("mul_7x6_lat", lat, 32'd3);
`else
    chk("mul_7x6_lat", lat, 32'd32);
`endif
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, lat);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, lat);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, lat);
    run_op("mul_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, lat);

    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, lat);
    chk("div_lat", lat, 32'd32);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, lat);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd8, 32'd14, lat);
    chk("divu_lat", lat, 32'd32);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd9, 32'd2, lat);

    run_op("div_by0", 3'b100, 32'd123, 32'd0, 5'd10, 32'hFFFF_FFFF, lat);
    chk("div_by0_lat", lat, 32'd0);
    run_op("rem_by0", 3'b110, 32'd123, 32'd0, 5'd11, 32'd123, lat);
    chk("rem_by0_lat", lat, 32'd0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, lat);
    chk("div_ovf_lat", lat, 32'd0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, lat);
    chk("rem_ovf_lat", lat, 32'd0);

    run_op("mul_rd0", 3'b000, 32'd5, 32'd5, 5'd0, 32'd25, lat);

    // Backpressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    wait_valid(lat);
    held = out_data;
    chk("bp_data", held, 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd11; in_rs2 = 32'd11; in_rd = 5'd20;
      @(posedge clk); #1;
      chk("bp_hold_data", out_data, 32'd14);
      chk("bp_hold_rd", {27'd0, out_rd}, 32'd9);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset during CALC iteration 10: the op must vanish.
    issue(3'b000, 32'd3, 32'h8000_0001, 5'd15);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    ghost = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    chk("midrst_no_result", ghost, 32'd0);
    run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 5'd14, 32'd9, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
